// File: rtl/riscv_pkg.sv
// ============================================================================
// riscv_pkg : RV32 opcode/funct constants, ALU select codes, decode types
// Rev 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam logic [6:0] c_opc_op     = 7'b0110011;
  localparam logic [6:0] c_opc_op_imm = 7'b0010011;
  localparam logic [6:0] c_opc_load   = 7'b0000011;
  localparam logic [6:0] c_opc_store  = 7'b0100011;
  localparam logic [6:0] c_opc_branch = 7'b1100011;

  localparam logic [2:0] c_f3_add  = 3'b000;
  localparam logic [2:0] c_f3_and  = 3'b111;
  localparam logic [2:0] c_f3_or   = 3'b110;
  localparam logic [2:0] c_f3_sltu = 3'b011;
  localparam logic [2:0] c_f3_beq  = 3'b000;
  localparam logic [2:0] c_f3_bne  = 3'b001;

  localparam logic [6:0] c_f7_base = 7'b0000000;
  localparam logic [6:0] c_f7_alt  = 7'b0100000;

  localparam logic [3:0] c_alu_and    = 4'b0000;
  localparam logic [3:0] c_alu_or     = 4'b0001;
  localparam logic [3:0] c_alu_add    = 4'b0010;
  localparam logic [3:0] c_alu_sub    = 4'b0110;
  localparam logic [3:0] c_alu_sltu   = 4'b0111;
  localparam logic [3:0] c_alu_nor    = 4'b1100;
  localparam logic [3:0] c_alu_eq     = 4'b1111;
  localparam logic [3:0] c_alu_pass_b = 4'b1000;

  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,
    IMM_I    = 2'd1,
    IMM_S    = 2'd2
  } imm_sel_e;

  typedef struct packed {
    logic [3:0] alu_sel;
    imm_sel_e   imm_sel;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       branch_inv;
    logic       illegal;
  } dec_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/alu_decode.sv
// ============================================================================
// alu_decode : combinational RV32 subset decoder (ALU select, control, imm sel)
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_decode
  import riscv_pkg::*;
(
  input  logic [31:0] i_instr,
  output dec_ctrl_t   o_ctrl
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic [4:0] w_rd;
  logic       w_unused_bits;

  assign w_opcode      = i_instr[6:0];
  assign w_funct3      = i_instr[14:12];
  assign w_funct7      = i_instr[31:25];
  assign w_rd          = i_instr[11:7];
  assign w_unused_bits = ^i_instr[24:15];

  logic [3:0] w_alu;
  imm_sel_e   w_imm;
  logic       w_hit;
  logic       w_rw;
  logic       w_mr;
  logic       w_mw;
  logic       w_br;
  logic       w_bi;

  always_comb begin
    w_alu = c_alu_pass_b;
    w_imm = IMM_NONE;
    w_hit = 1'b0;
    w_rw  = 1'b0;
    w_mr  = 1'b0;
    w_mw  = 1'b0;
    w_br  = 1'b0;
    w_bi  = 1'b0;
    case (w_opcode)
      c_opc_op: begin
        w_rw = 1'b1;
        if (w_funct7 == c_f7_alt) begin
          if (w_funct3 == c_f3_add) begin
            w_alu = c_alu_sub;
            w_hit = 1'b1;
          end
        end else if (w_funct7 == c_f7_base) begin
          w_hit = 1'b1;
          case (w_funct3)
            c_f3_add:  w_alu = c_alu_add;
            c_f3_and:  w_alu = c_alu_and;
            c_f3_or:   w_alu = c_alu_or;
            c_f3_sltu: w_alu = c_alu_sltu;
            default:   w_hit = 1'b0;
          endcase
        end
      end
      c_opc_op_imm: begin
        w_rw  = 1'b1;
        w_imm = IMM_I;
        w_hit = 1'b1;
        case (w_funct3)
          c_f3_add:  w_alu = c_alu_add;
          c_f3_and:  w_alu = c_alu_and;
          c_f3_or:   w_alu = c_alu_or;
          c_f3_sltu: w_alu = c_alu_sltu;
          default:   w_hit = 1'b0;
        endcase
      end
      c_opc_load: begin
        w_alu = c_alu_add;
        w_imm = IMM_I;
        w_mr  = 1'b1;
        w_rw  = 1'b1;
        w_hit = 1'b1;
      end
      c_opc_store: begin
        w_alu = c_alu_add;
        w_imm = IMM_S;
        w_mw  = 1'b1;
        w_hit = 1'b1;
      end
      c_opc_branch: begin
        w_alu = c_alu_eq;
        w_br  = 1'b1;
        w_hit = 1'b1;
        case (w_funct3)
          c_f3_beq: w_bi  = 1'b0;
          c_f3_bne: w_bi  = 1'b1;
          default:  w_hit = 1'b0;
        endcase
      end
      default: w_hit = 1'b0;
    endcase
  end

  // Unrecognised encodings collapse to a PASS-B bubble with rs2 as operand B.
  always_comb begin
    o_ctrl            = '0;
    o_ctrl.alu_sel    = w_hit ? w_alu : c_alu_pass_b;
    o_ctrl.imm_sel    = w_hit ? w_imm : IMM_NONE;
    o_ctrl.reg_write  = w_hit & w_rw & (w_rd != 5'd0);
    o_ctrl.mem_read   = w_hit & w_mr;
    o_ctrl.mem_write  = w_hit & w_mw;
    o_ctrl.branch     = w_hit & w_br;
    o_ctrl.branch_inv = w_hit & w_bi;
    o_ctrl.illegal    = ~w_hit;
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// id_ex_stage : ID/EX pipeline register with decode and 2-entry skid buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN:0]   A_out,
  output logic [XLEN:0]   B_out,
  output logic [3:0]      ALU_Sel_out,
  output logic [4:0]      out_rd,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_branch,
  output logic            out_branch_inv,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc
);

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] pc;
    logic [3:0]      alu_sel;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            branch_inv;
    logic            illegal;
  } entry_t;

  dec_ctrl_t       w_ctrl;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_opb;
  entry_t          w_new;

  alu_decode u_alu_decode (
    .i_instr (in_instr),
    .o_ctrl  (w_ctrl)
  );

  assign w_imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign w_imm_s = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};

  always_comb begin
    case (w_ctrl.imm_sel)
      IMM_I:   w_opb = w_imm_i;
      IMM_S:   w_opb = w_imm_s;
      default: w_opb = in_rs2_data;
    endcase
  end

  always_comb begin
    w_new            = '0;
    w_new.a          = in_rs1_data;
    w_new.b          = w_opb;
    w_new.pc         = in_pc;
    w_new.alu_sel    = w_ctrl.alu_sel;
    w_new.rd         = w_ctrl.reg_write ? in_instr[11:7] : 5'd0;
    w_new.reg_write  = w_ctrl.reg_write;
    w_new.mem_read   = w_ctrl.mem_read;
    w_new.mem_write  = w_ctrl.mem_write;
    w_new.branch     = w_ctrl.branch;
    w_new.branch_inv = w_ctrl.branch_inv;
    w_new.illegal    = w_ctrl.illegal;
  end

  entry_t r_main;
  entry_t r_skid;
  logic   r_main_valid;
  logic   r_skid_valid;
  logic   r_in_ready;

  entry_t w_main_nxt;
  entry_t w_skid_nxt;
  logic   w_main_valid_nxt;
  logic   w_skid_valid_nxt;
  logic   w_in_xfer;
  logic   w_out_xfer;

  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_xfer = r_main_valid & out_ready;

  // r_in_ready mirrors ~skid_valid, so an input never arrives while skid is full.
  always_comb begin
    w_main_nxt       = r_main;
    w_skid_nxt       = r_skid;
    w_main_valid_nxt = r_main_valid;
    w_skid_valid_nxt = r_skid_valid;
    if (flush) begin
      w_main_valid_nxt = 1'b0;
      w_skid_valid_nxt = 1'b0;
    end else if (w_out_xfer) begin
      if (r_skid_valid) begin
        w_main_nxt       = r_skid;
        w_skid_valid_nxt = 1'b0;
      end else if (w_in_xfer) begin
        w_main_nxt = w_new;
      end else begin
        w_main_valid_nxt = 1'b0;
      end
    end else if (w_in_xfer) begin
      if (!r_main_valid) begin
        w_main_nxt       = w_new;
        w_main_valid_nxt = 1'b1;
      end else begin
        w_skid_nxt       = w_new;
        w_skid_valid_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b0;
    end else begin
      r_main       <= w_main_nxt;
      r_skid       <= w_skid_nxt;
      r_main_valid <= w_main_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= ~w_skid_valid_nxt;
    end
  end

  assign in_ready       = r_in_ready;
  assign out_valid      = r_main_valid;
  assign A_out          = {1'b0, r_main.a};
  assign B_out          = {1'b0, r_main.b};
  assign ALU_Sel_out    = r_main.alu_sel;
  assign out_rd         = r_main.rd;
  assign out_reg_write  = r_main.reg_write;
  assign out_mem_read   = r_main.mem_read;
  assign out_mem_write  = r_main.mem_write;
  assign out_branch     = r_main.branch;
  assign out_branch_inv = r_main.branch_inv;
  assign out_illegal    = r_main.illegal;
  assign out_pc         = r_main.pc;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// tb_id_ex_stage : directed + random scoreboard bench for id_ex_stage
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_id_ex_stage;

  localparam int XLEN = 32;
  localparam int PW   = 113;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     in_instr = '0;
  logic [XLEN-1:0] in_rs1_data = '0;
  logic [XLEN-1:0] in_rs2_data = '0;
  logic [XLEN-1:0] in_pc = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN:0]   A_out;
  logic [XLEN:0]   B_out;
  logic [3:0]      ALU_Sel_out;
  logic [4:0]      out_rd;
  logic            out_reg_write;
  logic            out_mem_read;
  logic            out_mem_write;
  logic            out_branch;
  logic            out_branch_inv;
  logic            out_illegal;
  logic [XLEN-1:0] out_pc;

  id_ex_stage #(.XLEN(XLEN)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instr       (in_instr),
    .in_rs1_data    (in_rs1_data),
    .in_rs2_data    (in_rs2_data),
    .in_pc          (in_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .A_out          (A_out),
    .B_out          (B_out),
    .ALU_Sel_out    (ALU_Sel_out),
    .out_rd         (out_rd),
    .out_reg_write  (out_reg_write),
    .out_mem_read   (out_mem_read),
    .out_mem_write  (out_mem_write),
    .out_branch     (out_branch),
    .out_branch_inv (out_branch_inv),
    .out_illegal    (out_illegal),
    .out_pc         (out_pc)
  );

  always #5 clk = ~clk;

  logic [PW-1:0] dut_pay;
  assign dut_pay = {A_out, B_out, ALU_Sel_out, out_rd, out_reg_write, out_mem_read,
                    out_mem_write, out_branch, out_branch_inv, out_illegal, out_pc};

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  logic [PW-1:0] sb_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode written directly from the instruction-set table.
  function automatic logic [PW-1:0] model(input logic [31:0] ins, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] pc);
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [3:0]  sel;
    logic [31:0] opb;
    logic [4:0]  rd;
    logic        ill, rw, mr, mw, br, bi;
    op  = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    sel = 4'b1000;
    opb = b;
    ill = 1'b1; rw = 1'b0; mr = 1'b0; mw = 1'b0; br = 1'b0; bi = 1'b0;
    if (op == 7'h33) begin
      if      (f7 == 7'h00 && f3 == 3'd0) begin sel = 4'b0010; ill = 1'b0; end
      else if (f7 == 7'h20 && f3 == 3'd0) begin sel = 4'b0110; ill = 1'b0; end
      else if (f7 == 7'h00 && f3 == 3'd7) begin sel = 4'b0000; ill = 1'b0; end
      else if (f7 == 7'h00 && f3 == 3'd6) begin sel = 4'b0001; ill = 1'b0; end
      else if (f7 == 7'h00 && f3 == 3'd3) begin sel = 4'b0111; ill = 1'b0; end
      rw = ~ill;
    end else if (op == 7'h13) begin
      if      (f3 == 3'd0) begin sel = 4'b0010; ill = 1'b0; end
      else if (f3 == 3'd7) begin sel = 4'b0000; ill = 1'b0; end
      else if (f3 == 3'd6) begin sel = 4'b0001; ill = 1'b0; end
      else if (f3 == 3'd3) begin sel = 4'b0111; ill = 1'b0; end
      if (!ill) begin
        rw  = 1'b1;
        opb = {{20{ins[31]}}, ins[31:20]};
      end
    end else if (op == 7'h03) begin
      sel = 4'b0010; ill = 1'b0; mr = 1'b1; rw = 1'b1;
      opb = {{20{ins[31]}}, ins[31:20]};
    end else if (op == 7'h23) begin
      sel = 4'b0010; ill = 1'b0; mw = 1'b1;
      opb = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    end else if (op == 7'h63) begin
      if (f3 == 3'd0)      begin sel = 4'b1111; ill = 1'b0; br = 1'b1; end
      else if (f3 == 3'd1) begin sel = 4'b1111; ill = 1'b0; br = 1'b1; bi = 1'b1; end
    end
    if (ins[11:7] == 5'd0) rw = 1'b0;
    rd = rw ? ins[11:7] : 5'd0;
    return {1'b0, a, 1'b0, opb, sel, rd, rw, mr, mw, br, bi, ill, pc};
  endfunction

  logic          prev_stall = 1'b0;
  logic [PW-1:0] prev_pay   = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_payload", dut_pay, prev_pay);
      end
      if (flush) begin
        sb_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) check("spurious_output", out_valid, 1'b0);
          else check("payload", dut_pay, sb_q.pop_front());
        end
        if (in_valid && in_ready)
          sb_q.push_back(model(in_instr, in_rs1_data, in_rs2_data, in_pc));
      end
      prev_stall = out_valid && !out_ready && !flush;
      prev_pay   = dut_pay;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [31:0] ins, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] pc);
    in_valid    = 1'b1;
    in_instr    = ins;
    in_rs1_data = a;
    in_rs2_data = b;
    in_pc       = pc;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] pc);
    bit acc;
    acc = 1'b0;
    set_in(ins, a, b, pc);
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      cyc();
    end
    in_valid = 1'b0;
    check("send_accepted", acc, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rnd;
    logic [6:0]  ops [6];
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h7F};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_payload", dut_pay, '0);
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    check("release_no_edge_in_ready", in_ready, 1'b0);
    @(negedge clk);
    check("release_in_ready", in_ready, 1'b1);
    cyc();

    out_ready = 1'b1;
    send(32'h002081B3, 32'd5, 32'd7, 32'h100);
    @(negedge clk);
    check("add_latency_valid", out_valid, 1'b1);
    check("add_alu_sel", ALU_Sel_out, 4'b0010);
    check("add_A", A_out, 33'd5);
    check("add_B", B_out, 33'd7);
    check("add_rd", out_rd, 5'd3);
    check("add_reg_write", out_reg_write, 1'b1);
    cyc();

    send(32'hFFF00093, 32'd0, 32'h1234, 32'h104);
    @(negedge clk);
    check("addi_B", B_out, 33'h0_FFFF_FFFF);
    check("addi_alu_sel", ALU_Sel_out, 4'b0010);
    cyc();

    send(32'h0020A423, 32'h40, 32'h99, 32'h108);
    @(negedge clk);
    check("sw_B", B_out, 33'd8);
    check("sw_mem_write", out_mem_write, 1'b1);
    check("sw_reg_write", out_reg_write, 1'b0);
    cyc();

    send(32'h00209463, 32'd1, 32'd2, 32'h10C);
    @(negedge clk);
    check("bne_alu_sel", ALU_Sel_out, 4'b1111);
    check("bne_branch", out_branch, 1'b1);
    check("bne_branch_inv", out_branch_inv, 1'b1);
    cyc();

    send(32'h0000007F, 32'd3, 32'd4, 32'h110);
    @(negedge clk);
    check("ill_alu_sel", ALU_Sel_out, 4'b1000);
    check("ill_flag", out_illegal, 1'b1);
    check("ill_reg_write", out_reg_write, 1'b0);
    cyc();

    send(32'h40208233, 32'd9, 32'd4, 32'h114);
    send(32'h0020F2B3, 32'hF0F0, 32'h0FF0, 32'h118);
    send(32'h0020E333, 32'hF000, 32'h000F, 32'h11C);
    send(32'h0020B3B3, 32'd1, 32'd2, 32'h120);
    send(32'h0040A383, 32'h200, 32'd0, 32'h124);
    send(32'h00208463, 32'd6, 32'd6, 32'h128);
    send(32'h00208033, 32'd1, 32'd1, 32'h12C);
    send(32'hF800F093, 32'hFFFF, 32'd0, 32'h130);
    send(32'h02208233, 32'd1, 32'd1, 32'h134);
    repeat (2) cyc();

    out_ready = 1'b0;
    set_in(32'h002081B3, 32'hA1, 32'hA2, 32'h200);
    cyc();
    set_in(32'h40208233, 32'hB1, 32'hB2, 32'h204);
    cyc();
    set_in(32'h0040A383, 32'hC1, 32'hC2, 32'h208);
    @(negedge clk);
    check("bp_third_in_ready", in_ready, 1'b0);
    check("bp_out_valid", out_valid, 1'b1);
    cyc();
    repeat (3) cyc();
    out_ready = 1'b1;
    send(32'h0040A383, 32'hC1, 32'hC2, 32'h208);
    repeat (3) cyc();
    check("bp_drained", sb_q.size(), 0);

    out_ready = 1'b0;
    set_in(32'h00208033, 32'hD1, 32'hD2, 32'h300);
    cyc();
    set_in(32'h0020F2B3, 32'hE1, 32'hE2, 32'h304);
    cyc();
    set_in(32'h0020E333, 32'hF1, 32'hF2, 32'h308);
    flush = 1'b1;
    cyc();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    cyc();
    out_ready = 1'b1;
    repeat (4) cyc();

    out_ready = 1'b0;
    set_in(32'h002081B3, 32'h11, 32'h22, 32'h400);
    cyc();
    set_in(32'hFFF00093, 32'h33, 32'h44, 32'h404);
    cyc();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_payload", dut_pay, '0);
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midrst_release_in_ready", in_ready, 1'b1);
    cyc();
    out_ready = 1'b1;
    repeat (3) cyc();

    for (int i = 0; i < 80; i++) begin
      rnd = $urandom;
      if ($urandom_range(0, 6) < 6) rnd[6:0] = ops[$urandom_range(0, 5)];
      if ($urandom_range(0, 1) == 1) rnd[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      in_valid    = ($urandom_range(0, 3) != 0);
      in_instr    = rnd;
      in_rs1_data = $urandom;
      in_rs2_data = $urandom;
      in_pc       = $urandom;
      out_ready   = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 24) == 0);
      cyc();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (5) cyc();
    check("random_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
